// File: rtl/sys_array_stream_fetcher.sv
// Weight-stationary K x N row multiplier with valid/ready streams, bubble-carrying pipeline and deferred weight reload.
// Optional macro SYS_ARRAY_SATURATE_EN: widen the sums and clamp at the output register, raising a sticky sat flag.
module sys_array_stream_fetcher #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W_W  = 3,
    parameter int ARRAY_W_L  = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             weights_load,
    input  logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] weights,
    output logic                                             weights_valid,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [ARRAY_W_W-1:0][DATA_WIDTH-1:0]             in_row,
    input  logic                                             in_last,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [ARRAY_W_L-1:0][ACC_WIDTH-1:0]              out_row,
    output logic                                             out_last,
    output logic                                             busy,
    output logic [15:0]                                      frame_cnt,
    output logic                                             sat
);
    localparam int LAT    = ARRAY_W_W + ARRAY_W_L;
    localparam int PROD_W = 2 * DATA_WIDTH;
`ifdef SYS_ARRAY_SATURATE_EN
    localparam int SUM_W  = ACC_WIDTH + $clog2(ARRAY_W_W) + 1;
    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
`else
    localparam int SUM_W  = ACC_WIDTH;
`endif
    localparam int CNT_W  = $clog2(LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, LOAD} state_t;

    state_t                                             r_state;
    logic                                               r_pend;
    logic                                               r_wvalid;
    logic [ARRAY_W_W-1:0][ARRAY_W_L-1:0][DATA_WIDTH-1:0] r_weights;
    logic [LAT-1:0]                                     r_vld_p;
    logic [LAT-1:0]                                     r_last_p;
    logic [ARRAY_W_W-1:0][DATA_WIDTH-1:0]               r_row_p [ARRAY_W_W];
    logic signed [SUM_W-1:0]                            r_acc_p [1:LAT-1][ARRAY_W_L];
    logic                                               r_out_valid;
    logic                                               r_out_last;
    logic [ARRAY_W_L-1:0][ACC_WIDTH-1:0]                r_out_row;
    logic [CNT_W-1:0]                                   r_cnt;
    logic                                               r_busy;
    logic [15:0]                                        r_frame_cnt;

    logic                                               w_en;
    logic                                               w_accept;
    logic                                               w_hs;
    logic [CNT_W-1:0]                                   w_cnt_next;

    function automatic logic signed [SUM_W-1:0] mac_term(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
        logic signed [PROD_W-1:0] ax;
        logic signed [PROD_W-1:0] bx;
        logic signed [PROD_W-1:0] p;
        ax = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        bx = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        p  = ax * bx;
        return SUM_W'(p);
    endfunction

    function automatic logic [ACC_WIDTH-1:0] clamp_acc(input logic signed [SUM_W-1:0] v);
`ifdef SYS_ARRAY_SATURATE_EN
        if (v > ACC_MAX) return ACC_MAX[ACC_WIDTH-1:0];
        if (v < ACC_MIN) return ACC_MIN[ACC_WIDTH-1:0];
        return v[ACC_WIDTH-1:0];
`else
        return v;
`endif
    endfunction

    assign w_en     = !(r_out_valid && !out_ready);
    assign in_ready = w_en && r_wvalid && (r_state == RUN) && !r_pend;
    assign w_accept = in_valid && in_ready;
    assign w_hs     = r_out_valid && out_ready;

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_accept && !w_hs)
            w_cnt_next = r_cnt + CNT_W'(1);
        else if (!w_accept && w_hs)
            w_cnt_next = r_cnt - CNT_W'(1);
    end

    // Weight reload waits for an empty pipeline so in-flight beats never see new weights.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pend    <= 1'b0;
            r_wvalid  <= 1'b0;
            r_weights <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (weights_load) begin
                        r_weights <= weights;
                        r_wvalid  <= 1'b1;
                    end
                    if (r_wvalid) r_state <= RUN;
                end
                RUN: begin
                    if (weights_load) r_pend <= 1'b1;
                    if (r_pend) r_state <= DRAIN;
                end
                DRAIN: if (!r_busy) r_state <= LOAD;
                LOAD: begin
                    r_weights <= weights;
                    r_pend    <= 1'b0;
                    r_state   <= RUN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stage p0 captures the row; stages 1..K each add one product; the rest align to the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p  <= '0;
            r_last_p <= '0;
            for (int s = 0; s < ARRAY_W_W; s++) r_row_p[s] <= '0;
            for (int s = 1; s < LAT; s++)
                for (int j = 0; j < ARRAY_W_L; j++) r_acc_p[s][j] <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_row   <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_busy <= (w_cnt_next != '0);
            if (w_hs && r_out_last) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_en) begin
                r_vld_p    <= {r_vld_p[LAT-2:0], w_accept};
                r_last_p   <= {r_last_p[LAT-2:0], w_accept && in_last};
                r_row_p[0] <= in_row;
                for (int s = 1; s < ARRAY_W_W; s++) r_row_p[s] <= r_row_p[s-1];
                for (int j = 0; j < ARRAY_W_L; j++) begin
                    r_acc_p[1][j] <= mac_term(r_row_p[0][0], r_weights[0][j]);
                    for (int s = 2; s <= ARRAY_W_W; s++)
                        r_acc_p[s][j] <= r_acc_p[s-1][j] + mac_term(r_row_p[s-1][s-1], r_weights[s-1][j]);
                    for (int s = ARRAY_W_W + 1; s < LAT; s++)
                        r_acc_p[s][j] <= r_acc_p[s-1][j];
                    r_out_row[j] <= clamp_acc(r_acc_p[LAT-1][j]);
                end
                r_out_valid <= r_vld_p[LAT-1];
                r_out_last  <= r_last_p[LAT-1];
            end
        end
    end

`ifdef SYS_ARRAY_SATURATE_EN
    logic r_sat;
    logic w_clip;

    always_comb begin
        w_clip = 1'b0;
        for (int j = 0; j < ARRAY_W_L; j++)
            if (r_acc_p[LAT-1][j] > ACC_MAX || r_acc_p[LAT-1][j] < ACC_MIN) w_clip = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sat <= 1'b0;
        else if (w_en && r_vld_p[LAT-1] && w_clip)
            r_sat <= 1'b1;
    end

    assign sat = r_sat;
`else
    assign sat = 1'b0;
`endif

    assign weights_valid = r_wvalid;
    assign out_valid     = r_out_valid;
    assign out_row       = r_out_row;
    assign out_last      = r_out_last;
    assign busy          = r_busy;
    assign frame_cnt     = r_frame_cnt;
endmodule

// File: tb/tb_sys_array_stream_fetcher.sv
// Directed bench for sys_array_stream_fetcher: table-driven frames plus stall, deferred-load, saturation and reset sequences.
module tb_sys_array_stream_fetcher;
    localparam int DW = 8;
    localparam int K  = 3;
    localparam int N  = 4;
    localparam int AW = 16;
`ifdef SYS_ARRAY_SATURATE_EN
    localparam int SAT_V = 32767;
    localparam int SAT_F = 1;
`else
    localparam int SAT_V = -16384;
    localparam int SAT_F = 0;
`endif

    typedef logic [N-1:0][AW-1:0] orow_t;
    typedef struct {
        int row [K];
        int res [N];
        bit last;
    } vec_t;

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic                          weights_load = 1'b0;
    logic [K-1:0][N-1:0][DW-1:0]   weights = '0;
    logic                          weights_valid;
    logic                          in_valid = 1'b0;
    logic                          in_ready;
    logic [K-1:0][DW-1:0]          in_row = '0;
    logic                          in_last = 1'b0;
    logic                          out_valid;
    logic                          out_ready = 1'b1;
    orow_t                         out_row;
    logic                          out_last;
    logic                          busy;
    logic [15:0]                   frame_cnt;
    logic                          sat;

    sys_array_stream_fetcher #(
        .DATA_WIDTH(DW), .ARRAY_W_W(K), .ARRAY_W_L(N), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .weights_load(weights_load), .weights(weights),
        .weights_valid(weights_valid), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt), .sat(sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    orow_t rx_row[$];
    bit    rx_last[$];
    int    rx_cyc[$];
    int    acc_edge[$];
    int    total = 0;
    int    bad = 0;
    vec_t  tbl [4];

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                rx_row.push_back(out_row);
                rx_last.push_back(out_last);
                rx_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) acc_edge.push_back(cyc + 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rx_row.delete();
        rx_last.delete();
        rx_cyc.delete();
        acc_edge.delete();
    endtask

    task automatic set_vec(input int i, input int r0, input int r1, input int r2,
                           input int e0, input int e1, input int e2, input int e3, input bit l);
        tbl[i].row[0] = r0; tbl[i].row[1] = r1; tbl[i].row[2] = r2;
        tbl[i].res[0] = e0; tbl[i].res[1] = e1; tbl[i].res[2] = e2; tbl[i].res[3] = e3;
        tbl[i].last = l;
    endtask

    task automatic set_w_seq();
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) weights[k][j] = DW'(4 * k + j + 1);
    endtask

    task automatic set_w_const(input int v);
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) weights[k][j] = DW'(v);
    endtask

    task automatic put_row(input int r0, input int r1, input int r2, input bit lst);
        bit ok;
        ok = 1'b0;
        in_row[0] = DW'(r0);
        in_row[1] = DW'(r1);
        in_row[2] = DW'(r2);
        in_last  = lst;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic wait_rx(input int n, input string nm);
        for (int i = 0; i < 300 && rx_row.size() < n; i++) step();
        repeat (3) step();
        chk({nm, "_count"}, rx_row.size(), n);
    endtask

    task automatic check_tbl_rows(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            if (rx_row.size() > i) begin
                for (int j = 0; j < N; j++)
                    chk($sformatf("%s_r%0d_c%0d", nm, i, j), $signed(rx_row[i][j]), tbl[i].res[j]);
            end
        end
    endtask

    initial begin
        set_vec(0, 1, 0, 0,  1,  2,  3,  4, 1'b0);
        set_vec(1, 0, 1, 0,  5,  6,  7,  8, 1'b0);
        set_vec(2, 0, 0, 1,  9, 10, 11, 12, 1'b0);
        set_vec(3, 1, 1, 1, 15, 18, 21, 24, 1'b1);

        // reset values, asserted mid-cycle
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_weights_valid", weights_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", longint'(out_row), 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_sat", sat, 0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
            step();
        end
        set_w_seq();
        weights_load = 1'b1;
        step();
        weights_load = 1'b0;
        @(negedge clk);
        chk("load_weights_valid", weights_valid, 1);
        chk("load_in_ready_early", in_ready, 0);
        step();
        @(negedge clk);
        chk("run_in_ready", in_ready, 1);
        step();

        // basic frame
        clear_q();
        for (int i = 0; i < 4; i++) put_row(tbl[i].row[0], tbl[i].row[1], tbl[i].row[2], tbl[i].last);
        wait_rx(4, "basic");
        check_tbl_rows(4, "basic");
        for (int i = 0; i < 4; i++)
            if (rx_last.size() > i) chk($sformatf("basic_last%0d", i), rx_last[i], tbl[i].last);
        if (rx_cyc.size() == 4 && acc_edge.size() == 4) begin
            chk("basic_latency", rx_cyc[0] - acc_edge[0], 7);
            chk("basic_consecutive", rx_cyc[3] - rx_cyc[0], 3);
        end
        chk("basic_frame_cnt", frame_cnt, 1);
        chk("basic_busy_idle", busy, 0);

        // backpressure after the second result
        clear_q();
        fork
            begin : bp_src
                for (int i = 0; i < 4; i++) put_row(tbl[i].row[0], tbl[i].row[1], tbl[i].row[2], tbl[i].last);
            end
            begin : bp_sink
                int w;
                w = 0;
                while (rx_row.size() < 2 && w < 200) begin
                    step();
                    w++;
                end
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_stall_valid", out_valid, 1);
                    chk("bp_stall_in_ready", in_ready, 0);
                    chk("bp_stall_last", out_last, 0);
                    for (int j = 0; j < N; j++)
                        chk($sformatf("bp_stall_c%0d", j), $signed(out_row[j]), tbl[2].res[j]);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        wait_rx(4, "bp");
        check_tbl_rows(4, "bp");
        for (int i = 0; i < 4; i++)
            if (rx_last.size() > i) chk($sformatf("bp_last%0d", i), rx_last[i], tbl[i].last);
        chk("bp_frame_cnt", frame_cnt, 2);

        // deferred weight load with three beats in flight
        clear_q();
        put_row(1, 0, 0, 1'b0);
        put_row(0, 1, 0, 1'b0);
        put_row(0, 0, 1, 1'b1);
        set_w_const(2);
        weights_load = 1'b1;
        step();
        weights_load = 1'b0;
        begin : dl_next
            bit got;
            got = 1'b0;
            in_row[0] = DW'(1); in_row[1] = DW'(1); in_row[2] = DW'(1);
            in_last  = 1'b1;
            in_valid = 1'b1;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                chk("dl_ready_while_busy", in_ready && busy, 0);
                got = in_ready;
                step();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("dl_accept", got, 1);
        end
        wait_rx(4, "dl");
        check_tbl_rows(3, "dl_old");
        if (rx_row.size() == 4) begin
            for (int j = 0; j < N; j++) chk($sformatf("dl_new_c%0d", j), $signed(rx_row[3][j]), 6);
            chk("dl_last2", rx_last[2], 1);
            chk("dl_last3", rx_last[3], 1);
            chk("dl_last1", rx_last[1], 0);
        end
        chk("dl_frame_cnt", frame_cnt, 4);

        // saturation corner
        clear_q();
        chk("sat_before", sat, 0);
        set_w_const(-128);
        weights_load = 1'b1;
        step();
        weights_load = 1'b0;
        put_row(-128, -128, -128, 1'b1);
        wait_rx(1, "sat");
        if (rx_row.size() == 1)
            for (int j = 0; j < N; j++) chk($sformatf("sat_c%0d", j), $signed(rx_row[0][j]), SAT_V);
        chk("sat_flag", sat, SAT_F);
        chk("sat_frame_cnt", frame_cnt, 5);

        // reset with four beats in flight
        clear_q();
        set_w_seq();
        for (int i = 0; i < 4; i++) put_row(tbl[i].row[0], tbl[i].row[1], tbl[i].row[2], tbl[i].last);
        #3 reset = 1'b1;
        #1;
        chk("rm_out_valid", out_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_frame_cnt_now", frame_cnt, 0);
        chk("rm_sat_now", sat, 0);
        step();
        step();
        reset = 1'b0;
        begin : rm_watch
            int seen;
            seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
                step();
            end
            chk("rm_no_output", seen, 0);
        end
        chk("rm_weights_valid", weights_valid, 0);
        chk("rm_frame_cnt", frame_cnt, 0);
        chk("rm_in_ready", in_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sys_array_stream_fetcher.md
# sys_array_stream_fetcher

- Streaming, parametrised successor to the fixed-matrix systolic fetcher.
- Holds a weight-stationary ARRAY_W_W × ARRAY_W_L signed weight matrix.
- Accepts input rows one per cycle over a valid/ready stream and returns one result row per input row over a valid/ready stream. Frame length is unbounded and is delimited by a last flag.
- Sits between the row-fetch DMA and the result writer in the matrix-multiply datapath.

## Interface
Parameters:
- DATA_WIDTH, 8: signed operand width
- ARRAY_W_W, 3: inner dimension K; weight rows and input row length
- ARRAY_W_L, 4: output columns N; weight columns and output row length
- ACC_WIDTH, 16: signed result width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- weights_load  in  1  request to latch `weights`
- weights  in  [ARRAY_W_W][ARRAY_W_L]×DATA_WIDTH  signed weight matrix
- weights_valid  out  1  a weight matrix has been loaded since reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts input beat
- in_row  in  [ARRAY_W_W]×DATA_WIDTH  signed input row
- in_last  in  1  beat is the last row of the frame
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts output beat
- out_row  out  [ARRAY_W_L]×ACC_WIDTH  signed result row
- out_last  out  1  result row belongs to the input beat that had in_last set
- busy  out  1  at least one accepted beat is not yet delivered
- frame_cnt  out  16  count of completed frames (out_last handshakes); wraps
- sat  out  1  sticky saturation flag; see Configuration

## Operation
- Result: `out_row[j] = Σ_k in_row[k] * weights[k][j]`.
  - Products are 2·DATA_WIDTH signed.
  - Products are sign-extended and summed at ACC_WIDTH, modulo 2^ACC_WIDTH.
- Pipeline:
  - K×N PE grid with skewed input and deskewed output.
  - Each stage carries a valid tag and a last tag. An idle cycle inserts a bubble.
- Stall: enable = !(out_valid && !out_ready). When enable=0, the whole pipeline and output register freeze.
- in_ready = enable && weights_valid && state==RUN && !pend.
- Weight load:
  - weights_load in IDLE (busy=0): weights are latched on that edge and weights_valid becomes 1.
  - weights_load while busy=1: sets pend. in_ready is held 0, the pipeline drains, then the weights are latched on the first cycle with busy=0 and pend clears.
  - In-flight beats always use the old weights.
- FSM:
  - IDLE → RUN when weights_valid=1.
  - RUN → DRAIN when pend is set.
  - DRAIN → LOAD when busy=0.
  - LOAD (1 cycle, latch weights) → RUN.
- A weights_load arriving during LOAD is ignored.
- frame_cnt increments on each out_valid && out_ready && out_last.

## Timing
- Reset (async assert):
  - All pipeline state, weights, pend and sat are cleared.
  - Outputs: weights_valid=0, in_ready=0, out_valid=0, out_row=0, out_last=0, busy=0, frame_cnt=0, sat=0.
  - State goes to IDLE.
- Latency:
  - A beat accepted at edge t gives out_valid=1 after edge t+LAT, where LAT = ARRAY_W_W + ARRAY_W_L (7 at defaults).
  - Each stall cycle adds 1 to the latency.
- Throughput: 1 row/cycle with out_ready held at 1.
- out_row and out_last are held stable while out_valid && !out_ready.
- busy:
  - Set on the accepting edge.
  - Clears on the edge where the last in-flight beat handshakes out.
- Simultaneous events:
  - In the same cycle, an input accept and an output handshake are both performed.
  - weights_load in the same cycle as a final output handshake is a busy=1 request, so it is deferred through DRAIN/LOAD.
- Reset mid-frame: in-flight beats are discarded and no out_valid is produced. weights must be reloaded.

## Configuration
- SYS_ARRAY_SATURATE_EN defined:
  - The sum is computed internally at ACC_WIDTH+$clog2(ARRAY_W_W)+1 bits.
  - It is clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] at the output register.
  - sat sets on the first clamped delivered beat and stays set until reset.
- Undefined: results wrap modulo 2^ACC_WIDTH and sat is tied 0.

## Test plan
- Reset values:
  - Stimulus: assert reset mid-cycle.
  - Response: all outputs 0 immediately; in_ready stays 0 until a weights_load, then becomes 1 one cycle after LOAD.
- Basic frame:
  - Stimulus: load W = [[1,2,3,4],[5,6,7,8],[9,10,11,12]]; stream rows [1,0,0], [0,1,0], [0,0,1], [1,1,1] back-to-back, last on row 4.
  - Response: first out_valid 7 cycles after first accept. Outputs are [1,2,3,4], [5,6,7,8], [9,10,11,12], [15,18,21,24] on consecutive cycles, with out_last only on the 4th. frame_cnt=1.
- Backpressure:
  - Stimulus: same frame, out_ready=0 for 5 cycles after the second output.
  - Response: out_row held constant; in_ready=0 during the stall; no loss, duplication or reorder; all 4 results are correct.
- Deferred load:
  - Stimulus: weights_load with W=all 2 issued while 3 beats are in flight.
  - Response: in_ready=0 until busy=0. In-flight results use the old W. The next frame, row [1,1,1], gives [6,6,6,6].
- Saturation:
  - Stimulus: W all -128, in_row [-128,-128,-128]; true sum 49152.
  - With the macro: out_row all 32767 and sat=1.
  - Without the macro: out_row all -16384 and sat=0.
- Reset mid-frame:
  - Stimulus: assert reset with 4 beats in flight.
  - Response: no out_valid afterwards; weights_valid=0; frame_cnt=0.
